matrix_pixel_loader: RTL
========================

MATRIX_PIXEL_LOADER -- requirements
Module: matrix_pixel_loader

Interface
REQ-001 SHALL take parameters: SECTIONS, default 2, panel sections loaded per request, range 1..8.
REQ-002 SHALL take parameters: ROW_BITS, default 4, row address width.
REQ-003 SHALL take parameters: COL_BITS, default 6, column address width.
REQ-004 SHALL take parameters: RAM_LATENCY, default 2, framebuffer read latency in clocks, range 1..7.
REQ-005 SHALL take parameters: COL_INVERT, default 1, 1 = column address is bit-inverted before use.
REQ-006 SHALL have ports: clk_in  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-008 SHALL have ports: start  in  1  load request, one-cycle pulse.
REQ-009 SHALL have ports: row_address  in  ROW_BITS  row to load; column_address  in  COL_BITS  column to load.
REQ-010 SHALL have ports: brightness_mask  in  6  one-hot bit-plane select; rgb_enable  in  3  per-channel enable {B,G,R}.
REQ-011 SHALL have ports: ram_addr  out  SEC_BITS+ROW_BITS+COL_BITS  framebuffer address, with SEC_BITS = clog2(SECTIONS), min 1; ram_en  out  1  read enable.
REQ-012 SHALL have ports: ram_data  in  16  RGB565 read data; busy  out  1  load in progress; done  out  1  one-cycle completion pulse.
REQ-013 SHALL have ports: rgb_out  out  3*SECTIONS  bits [3s+2:3s] = {B,G,R} of section s.

Function
REQ-014 SHALL sample row_address and column_address at the start-accept edge and hold them internally for the whole load.
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPTURE, DONE.
REQ-016 SHALL go IDLE->ISSUE on start=1; start SHALL be ignored in every other state.
REQ-017 SHALL drive, in ISSUE, ram_addr = {s, row, COL_INVERT ? ~col : col} for section s, and ram_en = 1.
REQ-018 SHALL hold ram_addr and ram_en=1 from ISSUE through CAPTURE.
REQ-019 SHALL stay in WAIT for RAM_LATENCY-1 cycles; WAIT SHALL be skipped when RAM_LATENCY=1.
REQ-020 SHALL register ram_data into pixel register s in CAPTURE; then go to ISSUE for s+1, or to DONE after s = SECTIONS-1.
REQ-021 SHALL spend exactly RAM_LATENCY+1 cycles per section.
REQ-022 SHALL assert done for exactly one cycle, SECTIONS*(RAM_LATENCY+1)+1 cycles after the start-accept edge, then return to IDLE.
REQ-023 SHALL accept start again in the cycle following DONE.
REQ-024 SHALL hold busy = 1 in every state except IDLE.
REQ-025 SHALL compute rgb_out combinationally from the pixel registers, brightness_mask and rgb_enable, with no added latency.
REQ-026 SHALL expand fields to 6 bits: R6={R5,R5[4]}, G6=G6, B6={B5,B5[4]}.
REQ-027 SHALL form each channel bit as |(X6 & brightness_mask) & enable.
REQ-028 SHALL wrap the section counter to 0 at DONE.
REQ-029 SHALL not allow the section counter to exceed SECTIONS-1 for non-power-of-2 SECTIONS.

Reset
REQ-030 SHALL, on reset=1 in any state, enter IDLE at the next edge with busy=0, done=0, ram_en=0, ram_addr=0, and all pixel registers (and staging registers) = 0, so rgb_out=0.
REQ-031 SHALL abort any load on reset mid-operation, with no done pulse.
REQ-032 SHALL let reset take priority over a simultaneous start.

Configuration
REQ-033 SHALL, with PIXEL_LOADER_DOUBLE_BUFFER_EN defined, write CAPTURE into staging registers and copy all SECTIONS staging registers to the pixel registers at once in the DONE cycle, so rgb_out changes atomically.
REQ-034 SHALL, without PIXEL_LOADER_DOUBLE_BUFFER_EN, write CAPTURE directly into pixel register s, so section outputs update one at a time.

Structure
REQ-035 SHALL place in a shared package matrix_pkg: the FSM state enum, RGB565 field widths/offsets, the 6-bit brightness width constant, and the clog2-min-1 helper.
REQ-036 SHALL contain one sub-module, pixel_split (RGB565 + mask + enable -> 3 bits), instantiated once per section via generate.

Verification
REQ-037 SHALL cover: defaults, RAM model latency 2, start with row=3, col=5, memory[0x0FA]=0xF800, memory[0x4FA]=0x07E0, mask=0b100000, enable=3'b111 -> addresses 0x0FA then 0x4FA, done 7 cycles after start, rgb_out=6'b010_001.
REQ-038 SHALL cover: RAM_LATENCY=1, SECTIONS=4 -> no WAIT state, done 9 cycles after start, ram_addr section field 0,1,2,3.
REQ-039 SHALL cover: start pulsed again at cycle 3 of a load -> ignored, exactly one done, addresses unchanged.
REQ-040 SHALL cover: reset asserted in WAIT of section 1 -> next cycle busy=0, ram_en=0, rgb_out=0, no done; a fresh start completes normally.
REQ-041 SHALL cover: with PIXEL_LOADER_DOUBLE_BUFFER_EN, data 0xFFFF/0xFFFF after prior 0x0000 load -> rgb_out stays 0 until the DONE cycle, then all bits 1 together; without the macro, section 0 bits rise 3 cycles earlier.
REQ-042 SHALL cover: pixel 0x001F, mask sweep 0b000001..0b100000, enable=3'b100 -> blue bit 1 for every mask, red and green 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED-matrix pixel loader: FSM states,
// RGB565 field layout, bit-plane width and the min-1 clog2 helper.
package matrix_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   localparam int RGB_W    = 16;
   localparam int R_OFF    = 11;
   localparam int R_W      = 5;
   localparam int G_OFF    = 5;
   localparam int G_W      = 6;
   localparam int B_OFF    = 0;
   localparam int B_W      = 5;
   localparam int BRIGHT_W = 6;

   // A one-section panel still needs a one-bit section field in the address.
   function automatic int clog2_min1(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_pixel_loader_pixel_split.sv
// pixel_split: one RGB565 pixel, a one-hot bit-plane mask and channel enables
// reduced to the three {B,G,R} drive bits of one panel section.
module pixel_split
   import matrix_pkg::*;
(
   input  logic [RGB_W-1:0]    i_pixel,
   input  logic [BRIGHT_W-1:0] i_mask,
   input  logic [2:0]          i_enable,
   output logic [2:0]          o_rgb
);

   logic [BRIGHT_W-1:0] w_r6;
   logic [BRIGHT_W-1:0] w_g6;
   logic [BRIGHT_W-1:0] w_b6;

   // 5-bit channels are widened by replicating their MSB into the new LSB.
   assign w_r6 = {i_pixel[R_OFF +: R_W], i_pixel[R_OFF + R_W - 1]};
   assign w_g6 = i_pixel[G_OFF +: G_W];
   assign w_b6 = {i_pixel[B_OFF +: B_W], i_pixel[B_OFF + B_W - 1]};

   assign o_rgb = {(|(w_b6 & i_mask)) & i_enable[2],
                   (|(w_g6 & i_mask)) & i_enable[1],
                   (|(w_r6 & i_mask)) & i_enable[0]};

endmodule

// File: rtl/matrix_pixel_loader.sv
// Loads one pixel per panel section from a fixed-latency framebuffer RAM.
// Define PIXEL_LOADER_DOUBLE_BUFFER_EN to stage captures and update rgb_out atomically.
module matrix_pixel_loader
   import matrix_pkg::*;
#(
   parameter  int SECTIONS    = 2,
   parameter  int ROW_BITS    = 4,
   parameter  int COL_BITS    = 6,
   parameter  int RAM_LATENCY = 2,
   parameter  int COL_INVERT  = 1,
   localparam int SEC_BITS    = clog2_min1(SECTIONS),
   localparam int ADDR_W      = SEC_BITS + ROW_BITS + COL_BITS
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ROW_BITS-1:0]   row_address,
   input  logic [COL_BITS-1:0]   column_address,
   input  logic [BRIGHT_W-1:0]   brightness_mask,
   input  logic [2:0]            rgb_enable,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic                  ram_en,
   input  logic [RGB_W-1:0]      ram_data,
   output logic                  busy,
   output logic                  done,
   output logic [3*SECTIONS-1:0] rgb_out
);

   localparam int                WAIT_INIT = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;
   localparam logic [SEC_BITS-1:0] LAST_SEC = SEC_BITS'(SECTIONS - 1);

   state_t              r_state;
   logic [ROW_BITS-1:0] r_row;
   logic [COL_BITS-1:0] r_col;
   logic [SEC_BITS-1:0] r_sec;
   logic [2:0]          r_wait;
   logic [RGB_W-1:0]    r_pixel [SECTIONS];
`ifdef PIXEL_LOADER_DOUBLE_BUFFER_EN
   logic [RGB_W-1:0]    r_stage [SECTIONS];
`endif

   logic [COL_BITS-1:0] w_col;
   logic [SEC_BITS-1:0] w_sec_next;

   assign w_col      = (COL_INVERT != 0) ? ~column_address : column_address;
   assign w_sec_next = r_sec + 1'b1;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_row    <= '0;
         r_col    <= '0;
         r_sec    <= '0;
         r_wait   <= '0;
         ram_addr <= '0;
         ram_en   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int s = 0; s < SECTIONS; s++) begin
            r_pixel[s] <= '0;
`ifdef PIXEL_LOADER_DOUBLE_BUFFER_EN
            r_stage[s] <= '0;
`endif
         end
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_row    <= row_address;
                  r_col    <= w_col;
                  r_sec    <= '0;
                  ram_addr <= {{SEC_BITS{1'b0}}, row_address, w_col};
                  ram_en   <= 1'b1;
                  busy     <= 1'b1;
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_wait <= 3'(WAIT_INIT);
               if (RAM_LATENCY == 1) r_state <= ST_CAPTURE;
               else                  r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_wait == '0) r_state <= ST_CAPTURE;
               else              r_wait  <= r_wait - 1'b1;
            end
            ST_CAPTURE: begin
`ifdef PIXEL_LOADER_DOUBLE_BUFFER_EN
               r_stage[r_sec] <= ram_data;
`else
               r_pixel[r_sec] <= ram_data;
`endif
               if (r_sec == LAST_SEC) begin
`ifdef PIXEL_LOADER_DOUBLE_BUFFER_EN
                  // Last section bypasses staging so every section flips in DONE.
                  for (int s = 0; s < SECTIONS; s++)
                     r_pixel[s] <= (s == SECTIONS - 1) ? ram_data : r_stage[s];
`endif
                  r_sec   <= '0;
                  ram_en  <= 1'b0;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_sec    <= w_sec_next;
                  ram_addr <= {w_sec_next, r_row, r_col};
                  r_state  <= ST_ISSUE;
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < SECTIONS; g++) begin : g_sec
      pixel_split u_split (
         .i_pixel  (r_pixel[g]),
         .i_mask   (brightness_mask),
         .i_enable (rgb_enable),
         .o_rgb    (rgb_out[3*g +: 3])
      );
   end

endmodule
